// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle of the program-counter stage: branch decision and halt in,
// PC and fetch handshake out. Optional br_count exists only with PC_BRANCH_CNT_EN.
// master: the sequencer (drives pc/fetch_valid/flush/halted); slave: its peers.
interface pc_sequencer_if #(
    parameter int PC_W  = 8,
    parameter int OFF_W = 8
) ();
    logic             branch_taken;
    logic [OFF_W-1:0] branch_off;
    logic             halt_req;
    logic             fetch_ready;
    logic [PC_W-1:0]  pc;
    logic             fetch_valid;
    logic             flush;
    logic             halted;
`ifdef PC_BRANCH_CNT_EN
    logic [15:0]      br_count;
`endif

    modport master (
        input  branch_taken, branch_off, halt_req, fetch_ready,
`ifdef PC_BRANCH_CNT_EN
        output br_count,
`endif
        output pc, fetch_valid, flush, halted
    );

    modport slave (
        output branch_taken, branch_off, halt_req, fetch_ready,
`ifdef PC_BRANCH_CNT_EN
        input  br_count,
`endif
        input  pc, fetch_valid, flush, halted
    );
endinterface

// File: rtl/pc_sequencer.sv
// Purpose: program counter / next-PC stage with PC-relative branches, a one-cycle
//          flush bubble after a taken branch, and a sticky halt.
// Latency: all outputs registered; an input decision is visible one edge later.
// Backpressure: fetch_ready low in FETCH holds pc with fetch_valid kept high.
// Ports: clk, rst_n (async, active low); bus (pc_sequencer_if.master) carries
//        branch_taken/branch_off/halt_req/fetch_ready in, pc/fetch_valid/flush/
//        halted out. Optional macro PC_BRANCH_CNT_EN adds the 16-bit saturating
//        br_count of branches applied in FETCH.
// OFF_W must not exceed PC_W.
module pc_sequencer #(
    parameter int              PC_W     = 8,
    parameter int              OFF_W    = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_sequencer_if.master       bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_off_ext;
    logic            w_handshake;
    logic            w_br_apply;
    logic            r_fetch_valid;
    logic            r_flush;
    logic            r_halted;

    // Signed size cast sign-extends the offset; the add then wraps mod 2^PC_W.
    assign w_off_ext   = PC_W'($signed(bus.branch_off));
    assign w_handshake = r_fetch_valid & bus.fetch_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_br_apply  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                // Halt beats branch beats handshake. A branch wins even when
                // the current PC is being accepted in the same cycle.
                if (bus.halt_req) begin
                    w_state_nxt = ST_HALT;
                end else if (bus.branch_taken) begin
                    w_pc_nxt    = r_pc + w_off_ext;
                    w_state_nxt = ST_FLUSH;
                    w_br_apply  = 1'b1;
                end else if (w_handshake) begin
                    w_pc_nxt    = r_pc + PC_W'(1);
                end
            end
            ST_FLUSH: begin
                w_state_nxt = bus.halt_req ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_flush       <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            // Output flags are decoded from the next state so they are flops
            // that line up exactly with the state they describe.
            r_fetch_valid <= (w_state_nxt == ST_FETCH);
            r_flush       <= (w_state_nxt == ST_FLUSH);
            r_halted      <= (w_state_nxt == ST_HALT);
        end
    end

    assign bus.pc          = r_pc;
    assign bus.fetch_valid = r_fetch_valid;
    assign bus.flush       = r_flush;
    assign bus.halted      = r_halted;

`ifdef PC_BRANCH_CNT_EN
    logic [15:0] r_br_count;

    // Only counts in FETCH, so it is naturally frozen in HALT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_count <= 16'd0;
        end else if (w_br_apply && (r_br_count != 16'hFFFF)) begin
            r_br_count <= r_br_count + 16'd1;
        end
    end

    assign bus.br_count = r_br_count;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int PC_W  = 8;
    localparam int OFF_W = 8;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_FLUSH = 2;
    localparam int M_HALT  = 3;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    bit   chk_en;

    // Reference model: mode, pc and branch count as plain integers.
    int m_mode;
    int m_pc;
    int m_cnt;

    pc_sequencer_if #(.PC_W(PC_W), .OFF_W(OFF_W)) bus ();

    pc_sequencer #(.PC_W(PC_W), .OFF_W(OFF_W), .RESET_PC(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model advance on each rising edge from the inputs seen at that edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE;
            m_pc   = 0;
            m_cnt  = 0;
        end else begin
            case (m_mode)
                M_IDLE: m_mode = M_FETCH;
                M_FETCH: begin
                    if (bus.halt_req) begin
                        m_mode = M_HALT;
                    end else if (bus.branch_taken) begin
                        int off;
                        off    = int'(bus.branch_off) - (bus.branch_off[OFF_W-1] ? 256 : 0);
                        m_pc   = (m_pc + off) & 255;
                        m_mode = M_FLUSH;
                        if (m_cnt < 65535) m_cnt = m_cnt + 1;
                    end else if (bus.fetch_ready) begin
                        m_pc = (m_pc + 1) & 255;
                    end
                end
                M_FLUSH: m_mode = bus.halt_req ? M_HALT : M_FETCH;
                default: m_mode = M_HALT;
            endcase
        end
    end

    // Single compare process: every falling edge, DUT against model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc",          int'(bus.pc),          m_pc);
            chk("fetch_valid", int'(bus.fetch_valid), int'(m_mode == M_FETCH));
            chk("flush",       int'(bus.flush),       int'(m_mode == M_FLUSH));
            chk("halted",      int'(bus.halted),      int'(m_mode == M_HALT));
`ifdef PC_BRANCH_CNT_EN
            chk("br_count",    int'(bus.br_count),    m_cnt);
`endif
        end
    end

    // Drive one cycle's inputs, then land on the following falling edge.
    task automatic cyc(input logic bt, input logic [7:0] off, input logic h, input logic r);
        bus.branch_taken = bt;
        bus.branch_off   = off;
        bus.halt_req     = h;
        bus.fetch_ready  = r;
        @(negedge clk);
    endtask

    task automatic lit(input string nm, input logic [7:0] pc, input logic fv, input logic fl);
        chk({nm, ".pc"}, int'(bus.pc), int'(pc));
        chk({nm, ".fv"}, int'(bus.fetch_valid), int'(fv));
        chk({nm, ".flush"}, int'(bus.flush), int'(fl));
    endtask

    // Reset for two cycles, release on a falling edge, confirm IDLE half-cycle.
    task automatic do_reset();
        bus.branch_taken = 1'b0;
        bus.branch_off   = '0;
        bus.halt_req     = 1'b0;
        bus.fetch_ready  = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        lit("rst", 8'h00, 1'b0, 1'b0);
        chk("rst.halted", int'(bus.halted), 0);
        rst_n = 1'b1;
        #1 chk("idle.fv", int'(bus.fetch_valid), 0);
        cyc(1'b1, 8'h40, 1'b1, 1'b1);   // IDLE ignores all inputs
        lit("idle_exit", 8'h00, 1'b1, 1'b0);
    endtask

    task automatic rand_run(input int n, input int halt_div);
        for (int i = 0; i < n; i++) begin
            cyc(($urandom_range(3) == 0), 8'($urandom), ($urandom_range(halt_div - 1) == 0),
                ($urandom_range(3) != 0));
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        chk_en = 1'b0;
        rst_n  = 1'b1;
        bus.branch_taken = 1'b0;
        bus.branch_off   = '0;
        bus.halt_req     = 1'b0;
        bus.fetch_ready  = 1'b1;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        do_reset();

        // Free-running fetch from reset.
        cyc(0, 8'h00, 0, 1); lit("step1", 8'h01, 1, 0);
        cyc(0, 8'h00, 0, 1); lit("step2", 8'h02, 1, 0);
        cyc(0, 8'h00, 0, 1); lit("step3", 8'h03, 1, 0);
        // Negative branch wrapping below zero, then wrap at the top.
        cyc(1, 8'hFC, 0, 1); lit("br_to_ff", 8'hFF, 0, 1);
        cyc(1, 8'h40, 0, 1); lit("flush_ign", 8'hFF, 1, 0);
        cyc(0, 8'h00, 0, 1); lit("wrap", 8'h00, 1, 0);
        // Branch at 0x10 by -4 with fetch_ready high, then low.
        cyc(1, 8'h10, 0, 0); lit("to10", 8'h10, 0, 1);
        cyc(0, 8'h00, 0, 0); lit("at10", 8'h10, 1, 0);
        cyc(1, 8'hFC, 0, 1); lit("br0c_rdy", 8'h0C, 0, 1);
        cyc(0, 8'h00, 0, 1); lit("resume0c", 8'h0C, 1, 0);
        cyc(0, 8'h00, 0, 1); lit("step0d", 8'h0D, 1, 0);
        cyc(1, 8'h03, 0, 0); cyc(0, 8'h00, 0, 0); lit("at10b", 8'h10, 1, 0);
        cyc(1, 8'hFC, 0, 0); lit("br0c_nordy", 8'h0C, 0, 1);
        cyc(0, 8'h00, 0, 0); lit("resume0c_b", 8'h0C, 1, 0);
        // Stall at 0x05 for three cycles, accept on the fourth.
        cyc(1, 8'hF9, 0, 0); cyc(0, 8'h00, 0, 0); lit("at05", 8'h05, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 8'h00, 0, 0); lit("stall05", 8'h05, 1, 0);
        end
        cyc(0, 8'h00, 0, 1); lit("accept06", 8'h06, 1, 0);

        rand_run(400, 1000000);

        // Asynchronous reset landing in the middle of a FLUSH cycle.
        cyc(0, 8'h00, 0, 1);
        while (m_mode != M_FETCH) cyc(0, 8'h00, 0, 1);
        cyc(1, 8'h33, 0, 1);
        chk("pre_rst.flush", int'(bus.flush), 1);
        #1 rst_n = 1'b0;
        #1 lit("async_rst", 8'h00, 0, 0);
        chk("async_rst.halted", int'(bus.halted), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("re_idle.fv", int'(bus.fetch_valid), 0);
        cyc(0, 8'h00, 0, 1); lit("restart", 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 1); lit("restart1", 8'h01, 1, 0);

        // Random segments including occasional halts, each from a fresh reset.
        for (int s = 0; s < 4; s++) begin
            do_reset();
            rand_run(250, 40);
        end

        // Halt and branch together at 0x20: halt wins, no flush, pc frozen.
        do_reset();
        cyc(1, 8'h20, 0, 1); lit("to20", 8'h20, 0, 1);
        cyc(0, 8'h00, 0, 1); lit("at20", 8'h20, 1, 0);
        cyc(1, 8'h05, 1, 1); lit("halt20", 8'h20, 0, 0);
        chk("halt20.halted", int'(bus.halted), 1);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 8'($urandom), ($urandom_range(1) == 0), 1);
            lit("halt_hold", 8'h20, 0, 0);
            chk("halt_hold.halted", int'(bus.halted), 1);
`ifdef PC_BRANCH_CNT_EN
            chk("halt_hold.br_count", int'(bus.br_count), 1);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter / next-PC stage directly downstream of the branch-decision gate.
- The branch-decision gate computes branch_taken = flag AND branch; this block consumes that result.
- Holds the PC and presents it to instruction memory through a valid/ready fetch handshake.
- Applies PC-relative branches, inserts a one-cycle flush bubble after a taken branch, and supports a sticky halt.

Parameters:
- PC_W, 8: PC width in bits; all PC arithmetic is modulo 2^PC_W.
- OFF_W, 8: branch offset width in bits; the offset is two's-complement signed and must satisfy OFF_W <= PC_W.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- branch_taken  in  1  taken-branch decision (flag AND branch) from the upstream gate.
- branch_off  in  OFF_W  signed PC-relative branch offset.
- halt_req  in  1  request to stop fetching; sticky once accepted.
- fetch_ready  in  1  instruction memory accepts the current PC.
- pc  out  PC_W  current program counter.
- fetch_valid  out  1  pc is a valid fetch request.
- flush  out  1  one-cycle pulse telling downstream stages to squash the in-flight instruction.
- halted  out  1  block is in HALT.

Behaviour:
- States: IDLE, FETCH, FLUSH, HALT. All outputs are registered.
- Reset (asynchronous, takes effect immediately, also mid-operation): state=IDLE, pc=RESET_PC, fetch_valid=0, flush=0, halted=0.
- IDLE: lasts one cycle after reset release, then goes to FETCH. No PC change. Inputs are ignored.
- FETCH: fetch_valid=1. Handshake occurs in a cycle where fetch_valid=1 and fetch_ready=1. Per-edge priority:
  - 1) halt_req=1 -> go to HALT; pc unchanged.
  - 2) branch_taken=1 -> pc <= pc + sign_extend(branch_off), wrap modulo 2^PC_W; go to FLUSH. Applies whether or not the handshake occurs that cycle.
  - 3) handshake -> pc <= pc + 1, wrap; stay in FETCH.
  - 4) otherwise -> hold pc; stay in FETCH.
- FLUSH: exactly one cycle.
  - flush=1, fetch_valid=0.
  - branch_taken and fetch_ready are ignored.
  - halt_req=1 -> go to HALT; otherwise go to FETCH. pc is unchanged.
- HALT: fetch_valid=0, flush=0, halted=1, pc frozen. Only reset exits this state.
- Output timing: flush and fetch_valid reflect the current state, so flush is high for the single cycle following the taken-branch edge.
- Wrap: pc=2^PC_W-1 with a handshake gives 0. Negative offsets wrap the same way.
- branch_taken is not latched; a pulse arriving during IDLE, FLUSH or HALT is lost.

Optional Feature:
- Macro: PC_BRANCH_CNT_EN.
- Defined:
  - Adds output br_count (16 bits), reset to 0.
  - br_count increments on each edge where a branch is applied in FETCH.
  - br_count saturates at 16'hFFFF and freezes in HALT.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset release, fetch_ready=1 constantly, no branches -> pc stays 0 during IDLE, then fetch_valid=1 and pc steps 0,1,2,3 on successive cycles.
- PC_W=8, pc=0xFF, handshake -> pc=0x00 next cycle with no glitch on fetch_valid.
- pc=0x10, branch_taken=1, branch_off=0xFC (-4) -> pc=0x0C; flush=1 and fetch_valid=0 for one cycle; fetching resumes from 0x0C. The same case with fetch_ready=0 during the branch cycle gives the identical result.
- fetch_ready=0 for 3 cycles at pc=0x05 -> pc holds 0x05 and fetch_valid stays 1; handshake on the 4th cycle -> pc=0x06.
- halt_req=1 and branch_taken=1 in the same FETCH cycle at pc=0x20 -> halted=1, pc stays 0x20, flush never asserts; later branch_taken pulses are ignored; with PC_BRANCH_CNT_EN defined, br_count is unchanged.
- rst_n driven low asynchronously mid-FLUSH -> all outputs return to reset values before the next clock edge; after release, IDLE lasts one cycle, then fetching restarts at RESET_PC.
